// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-setting controller.
// Keeps hh:mm:ss as six BCD digits, advanced by a 1 Hz enable, and lets the
// user set hours and minutes with two debounced push-buttons
// (mode: RUN -> SET_HOUR -> SET_MIN -> RUN, inc: bump the field being set).
//
// Handshake note: there is no valid/ready pair in this block. A debounced
// button press is a one-cycle strobe (valid with implied ready), and tick_1hz
// is a one-cycle enable; every strobe is consumed on the clock edge that ends
// the cycle in which it is high, and nothing is ever back-pressured.
// The FSM state is visible on the mode output.
module clock_set_ctrl #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] h0,
  output logic [3:0] h1,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam int             CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Button path: index 0 = mode button, index 1 = inc button
  // ---------------------------------------------------------------------
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db_lvl;
  logic [1:0]    db_prev;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic          mode_press;
  logic          inc_press;

  assign btn_raw = {btn_inc, btn_mode};

  // Two-flop synchronizer for the asynchronous raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: the level must differ for DB_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl    <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == db_lvl[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == CNT_MAX) begin
          db_lvl[b] <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Previous debounced level, used to find the rising edge (press) only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= 2'b00;
    end else begin
      db_prev <= db_lvl;
    end
  end

  assign press      = db_lvl & ~db_prev;
  assign mode_press = press[0];
  assign inc_press  = press[1];

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  state_t state;
  state_t state_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: each mode press steps RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      case (state)
        ST_RUN:      state_nxt = ST_SET_HOUR;
        ST_SET_HOUR: state_nxt = ST_SET_MIN;
        ST_SET_MIN:  state_nxt = ST_RUN;
        default:     state_nxt = ST_RUN;
      endcase
    end
  end

  // FSM outputs: the mode code is the state encoding itself.
  always_comb begin
    mode = state;
  end

  // ---------------------------------------------------------------------
  // Time digits, blink and day pulse
  // ---------------------------------------------------------------------
  logic [3:0] s0_n, s1_n, m0_n, m1_n, h0_n, h1_n;
  logic       blink_n;
  logic       day_n;

  // Next digit values: full BCD carry chain in RUN, field increments in SET modes.
  always_comb begin
    s0_n  = s0;
    s1_n  = s1;
    m0_n  = m0;
    m1_n  = m1;
    h0_n  = h0;
    h1_n  = h1;
    day_n = 1'b0;
    case (state)
      ST_RUN: begin
        // A tick is applied even when a mode press arrives in the same cycle.
        if (tick_1hz) begin
          if (s0 == 4'd9) begin
            s0_n = 4'd0;
            if (s1 == 4'd5) begin
              s1_n = 4'd0;
              if (m0 == 4'd9) begin
                m0_n = 4'd0;
                if (m1 == 4'd5) begin
                  m1_n = 4'd0;
                  if (h1 == 4'd2 && h0 == 4'd3) begin
                    h1_n  = 4'd0;
                    h0_n  = 4'd0;
                    day_n = 1'b1;
                  end else if (h0 == 4'd9) begin
                    h0_n = 4'd0;
                    h1_n = h1 + 4'd1;
                  end else begin
                    h0_n = h0 + 4'd1;
                  end
                end else begin
                  m1_n = m1 + 4'd1;
                end
              end else begin
                m0_n = m0 + 4'd1;
              end
            end else begin
              s1_n = s1 + 4'd1;
            end
          end else begin
            s0_n = s0 + 4'd1;
          end
        end
      end
      ST_SET_HOUR: begin
        // Mode press wins over a simultaneous inc press.
        if (!mode_press && inc_press) begin
          if (h1 == 4'd2 && h0 == 4'd3) begin
            h1_n = 4'd0;
            h0_n = 4'd0;
          end else if (h0 == 4'd9) begin
            h0_n = 4'd0;
            h1_n = h1 + 4'd1;
          end else begin
            h0_n = h0 + 4'd1;
          end
        end
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          // Leaving the set sequence restarts the minute at :00.
          s0_n = 4'd0;
          s1_n = 4'd0;
        end else if (inc_press) begin
          if (m0 == 4'd9) begin
            m0_n = 4'd0;
            m1_n = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
          end else begin
            m0_n = m0 + 4'd1;
          end
        end
      end
      default: begin
        s0_n = s0;
      end
    endcase
  end

  // Next blink phase: 0 in RUN, restart at 1 on entering a SET mode or on inc, else toggle per tick.
  always_comb begin
    blink_n = blink;
    if (state_nxt == ST_RUN) begin
      blink_n = 1'b0;
    end else if (state_nxt != state) begin
      blink_n = 1'b1;
    end else if (inc_press) begin
      blink_n = 1'b1;
    end else if (tick_1hz) begin
      blink_n = ~blink;
    end
  end

  // Register the time digits, blink phase and day rollover pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0        <= 4'd0;
      s1        <= 4'd0;
      m0        <= 4'd0;
      m1        <= 4'd0;
      h0        <= 4'd0;
      h1        <= 4'd0;
      blink     <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      s0        <= s0_n;
      s1        <= s1_n;
      m0        <= m0_n;
      m1        <= m1_n;
      h0        <= h0_n;
      h1        <= h1_n;
      blink     <= blink_n;
      day_pulse <= day_n;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: drives ticks and button presses, keeps a
// seconds-of-day reference model, and checks snapshots through a queue.
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int W  = 36;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc  = 1'b0;
  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  always #5 clk = ~clk;

  clock_set_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .s0        (s0),
    .s1        (s1),
    .m0        (m0),
    .m1        (m1),
    .h0        (h0),
    .h1        (h1),
    .mode      (mode),
    .blink     (blink),
    .day_pulse (day_pulse)
  );

  // ---------------------------------------------------------------------
  // Reference model (time as seconds of day)
  // ---------------------------------------------------------------------
  int m_t        = 0;
  int m_mode     = 0;
  bit m_blink    = 1'b0;
  bit exp_pulse  = 1'b0;
  bit pend_pulse = 1'b0;
  int exp_cnt    = 0;
  int dut_day_cnt = 0;

  // Count day pulses seen on the DUT (value held during the cycle before each edge).
  always @(posedge clk) begin
    if (day_pulse === 1'b1) dut_day_cnt <= dut_day_cnt + 1;
  end

  function automatic void model_reset();
    m_t        = 0;
    m_mode     = 0;
    m_blink    = 1'b0;
    exp_pulse  = 1'b0;
    pend_pulse = 1'b0;
  endfunction

  function automatic void model_event(bit mp, bit ip, bit tk);
    int h, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    case (m_mode)
      0: begin
        if (tk) begin
          m_t = (m_t + 1) % 86400;
          if (m_t == 0) pend_pulse = 1'b1;
        end
        if (mp) begin
          m_mode  = 1;
          m_blink = 1'b1;
        end
      end
      1: begin
        if (mp) begin
          m_mode  = 2;
          m_blink = 1'b1;
        end else if (ip) begin
          m_t     = ((h + 1) % 24) * 3600 + mi * 60 + s;
          m_blink = 1'b1;
        end else if (tk) begin
          m_blink = ~m_blink;
        end
      end
      default: begin
        if (mp) begin
          m_mode  = 0;
          m_blink = 1'b0;
          m_t     = h * 3600 + mi * 60;
        end else if (ip) begin
          m_t     = h * 3600 + ((mi + 1) % 60) * 60 + s;
          m_blink = 1'b1;
        end else if (tk) begin
          m_blink = ~m_blink;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    int h, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            2'(m_mode), m_blink, exp_pulse, 8'(exp_cnt)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {h1, h0, m1, m0, s1, s0, mode, blink, day_pulse, 8'(dut_day_cnt)};
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  event         chk_ev;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic expect_now(input string nm);
    exp_q.push_back(model_vec());
    name_q.push_back(nm);
    ->chk_ev;
  endtask

  // Monitor: pops every queued expectation and compares against the DUT outputs.
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    string        nm;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = dut_vec();
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s: got time=%h mode=%0d blink=%b dp=%b dcnt=%0d, expected time=%h mode=%0d blink=%b dp=%b dcnt=%0d",
                   nm, g[35:12], g[11:10], g[9], g[8], g[7:0],
                   e[35:12], e[11:10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (all drive happens 1 time unit after a rising edge)
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    exp_cnt    = exp_cnt + int'(exp_pulse);
    exp_pulse  = pend_pulse;
    pend_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    model_event(1'b0, 1'b0, 1'b1);
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  // Clean press; optionally a tick lands exactly on the edge that consumes the press.
  task automatic press_evt(input bit mp, input bit ip, input bit tk);
    btn_mode = mp;
    btn_inc  = ip;
    repeat (DB + 2) step();
    tick_1hz = tk;
    model_event(mp, ip, tk);
    step();
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DB + 4) step();
  endtask

  task automatic presses(input bit mp, input bit ip, input int n);
    for (int k = 0; k < n; k++) press_evt(mp, ip, 1'b0);
  endtask

  task automatic drive_inc_pattern(input logic [15:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      btn_inc = pat[k];
      step();
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_state");
    rst_n = 1'b1;
    step();
    expect_now("after_reset_release");

    // Carry chain from 00:00:00 with irregular tick spacing.
    for (int i = 1; i <= 3600; i++) begin
      do_tick();
      repeat ($urandom_range(0, 2)) step();
      if (i == 1)    expect_now("carry_tick1");
      if (i == 60)   expect_now("carry_tick60");
      if (i == 599)  expect_now("carry_tick599");
      if (i == 3600) expect_now("carry_tick3600");
    end

    // Setting sequence.
    do_reset();
    ticks(7);
    expect_now("run_7s");
    press_evt(1'b0, 1'b1, 1'b0);
    expect_now("inc_ignored_in_run");
    press_evt(1'b1, 1'b0, 1'b0);
    expect_now("enter_set_hour");
    do_tick();
    expect_now("set_hour_tick_frozen");
    do_tick();
    expect_now("set_hour_blink_toggle");
    presses(1'b0, 1'b1, 25);
    expect_now("hour_25_inc");
    press_evt(1'b1, 1'b0, 1'b0);
    expect_now("enter_set_min");
    presses(1'b0, 1'b1, 61);
    expect_now("min_61_inc");
    press_evt(1'b1, 1'b0, 1'b0);
    expect_now("leave_set_min");

    // Day rollover: set 23:59:58, then two ticks.
    press_evt(1'b1, 1'b0, 1'b0);
    presses(1'b0, 1'b1, 22);
    press_evt(1'b1, 1'b0, 1'b0);
    presses(1'b0, 1'b1, 58);
    press_evt(1'b1, 1'b0, 1'b0);
    ticks(58);
    expect_now("pre_roll_235958");
    do_tick();
    expect_now("roll_235959");
    do_tick();
    expect_now("roll_000000_pulse");
    step();
    expect_now("roll_pulse_one_cycle");
    repeat (3) step();
    expect_now("roll_pulse_gone");

    // Debounce behaviour in SET_HOUR.
    press_evt(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_inc_pattern(16'h0007, 7);
    repeat (8) step();
    expect_now("short_pulses_ignored");
    drive_inc_pattern(16'h00ED, 9);
    btn_inc = 1'b1;
    repeat (30) step();
    model_event(1'b0, 1'b1, 1'b0);
    drive_inc_pattern(16'h0012, 6);
    btn_inc = 1'b0;
    repeat (12) step();
    expect_now("bounce_hold_single_inc");

    // Simultaneous events.
    press_evt(1'b1, 1'b1, 1'b0);
    expect_now("mode_beats_inc");
    press_evt(1'b1, 1'b0, 1'b0);
    ticks(5);
    press_evt(1'b1, 1'b0, 1'b1);
    expect_now("run_tick_and_mode");
    press_evt(1'b1, 1'b0, 1'b0);
    press_evt(1'b1, 1'b0, 1'b1);
    expect_now("setmin_tick_and_mode");

    // Randomized mix of ticks and presses in every mode.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3: do_tick();
        4, 5:       press_evt(1'b1, 1'b0, 1'b0);
        6, 7, 8:    press_evt(1'b0, 1'b1, 1'b0);
        9:          press_evt(1'b1, 1'b1, 1'b0);
        10:         press_evt(1'b1, 1'b0, 1'b1);
        default:    press_evt(1'b0, 1'b1, 1'b1);
      endcase
      repeat ($urandom_range(0, 3)) step();
      expect_now($sformatf("random_op%0d_kind%0d", n, r));
    end

    // Asynchronous reset at 12:34:56 in SET_MIN with a debounce in flight.
    do_reset();
    press_evt(1'b1, 1'b0, 1'b0);
    presses(1'b0, 1'b1, 12);
    press_evt(1'b1, 1'b0, 1'b0);
    presses(1'b0, 1'b1, 34);
    press_evt(1'b1, 1'b0, 1'b0);
    ticks(56);
    press_evt(1'b1, 1'b0, 1'b0);
    press_evt(1'b1, 1'b0, 1'b0);
    expect_now("pre_reset_123456_setmin");
    btn_inc = 1'b1;
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_now("async_reset_immediate");
    btn_inc = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (DB + 6) step();
    expect_now("after_async_reset");
    press_evt(1'b0, 1'b1, 1'b0);
    expect_now("post_reset_inc_ignored");

    repeat (2) step();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
